temperature_encoder: RTL and testbench

TEMPERATURE_ENCODER -- requirements
Module: temperature_encoder

---
 rtl/temperature_encoder.sv | 187 ++++++++++++++++++
 tb/tb_temperature_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/temperature_encoder.sv
// temperature_encoder
// Converts a temperature difference (tempc - tc_base) into a signed-magnitude
// 16-bit sensor word. The value is scaled by 32/(tc_ref^2) and computed with a
// 15-cycle restoring divider.
//
// Ports:
//   clk      - rising-edge clock for all state
//   rst      - synchronous active-high reset
//   start    - encode request, accepted only while idle
//   tc_base  - environment base degree, signed 32-bit
//   tc_ref   - system work voltage, unsigned 8-bit
//   tempc    - target temperature in Celsius, signed 32-bit
//   adc_data - {sign, magnitude[14:0]}; sign=1 means below base
//   busy     - conversion in progress
//   done     - one-cycle pulse when adc_data is valid
//   sat      - last result was clamped to full scale
//   err      - last request had tc_ref = 0
module temperature_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] tc_base,
    input  logic [7:0]  tc_ref,
    input  logic [31:0] tempc,
    output logic [15:0] adc_data,
    output logic        busy,
    output logic        done,
    output logic        sat,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] temp_q, temp_d;
    logic [7:0]  ref_q, ref_d;
    logic        sgn_q, sgn_d;
    logic [37:0] rem_q, rem_d;
    logic [37:0] dvs_q, dvs_d;
    logic [14:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adc_q, adc_d;
    logic        sat_q, sat_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [32:0] diff;
    logic [32:0] mag;
    logic [37:0] num;
    logic [15:0] scale;
    logic [37:0] limit;
    logic        fits;
    logic [37:0] trial;
    logic [14:0] quo_next;

    // Arithmetic on the latched operands. The difference is sign-extended to
    // 33 bits so that no pair of 32-bit inputs can wrap; its magnitude then
    // fits in 33 bits and the scaled numerator in 38 bits.
    always_comb begin
        diff     = {temp_q[31], temp_q} - {base_q[31], base_q};
        mag      = diff[32] ? (~diff + 33'd1) : diff;
        num      = {mag, 5'b00000};
        scale    = {8'd0, ref_q} * {8'd0, ref_q};
        limit    = {7'd0, scale, 15'd0};
        fits     = (rem_q >= dvs_q);
        trial    = rem_q - dvs_q;
        quo_next = {quo_q[13:0], fits};
    end

    // Next-state logic. The divisor starts aligned at scale<<14 and shifts
    // right once per step; because num < scale<<15 is guaranteed on entry to
    // DIV, fifteen steps produce the complete quotient.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        temp_d  = temp_q;
        ref_d   = ref_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        adc_d   = adc_q;
        sat_d   = sat_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = tc_base;
                    temp_d  = tempc;
                    ref_d   = tc_ref;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (scale == 16'd0) begin
                    err_d   = 1'b1;
                    sat_d   = 1'b0;
                    adc_d   = 16'h0000;
                    state_d = DONE;
                end else if (num >= limit) begin
                    sat_d   = 1'b1;
                    err_d   = 1'b0;
                    adc_d   = {diff[32], 15'h7FFF};
                    state_d = DONE;
                end else begin
                    sgn_d   = diff[32];
                    rem_d   = num;
                    dvs_d   = {8'd0, scale, 14'd0};
                    quo_d   = 15'd0;
                    cnt_d   = 4'd0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (fits) begin
                    rem_d = trial;
                end
                dvs_d = dvs_q >> 1;
                quo_d = quo_next;
                cnt_d = cnt_q + 4'd1;
                // A zero quotient is reported as +0 even for negative differences.
                if (cnt_q == 4'd14) begin
                    adc_d   = {sgn_q & (quo_next != 15'd0), quo_next};
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers. Reset overrides any state, including an
    // in-flight division, so an aborted conversion never raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= 32'd0;
            temp_q  <= 32'd0;
            ref_q   <= 8'd0;
            sgn_q   <= 1'b0;
            rem_q   <= 38'd0;
            dvs_q   <= 38'd0;
            quo_q   <= 15'd0;
            cnt_q   <= 4'd0;
            adc_q   <= 16'h0000;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            temp_q  <= temp_d;
            ref_q   <= ref_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            adc_q   <= adc_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign adc_data = adc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sat      = sat_q;
    assign err      = err_q;

endmodule

// File: tb/tb_temperature_encoder.sv
// tb_temperature_encoder
// Directed bench for temperature_encoder. Each request's expected result comes
// from an integer reference model. It is queued when the request is driven and
// compared when done is seen, together with the done latency.
module tb_temperature_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] tc_base;
    logic [7:0]  tc_ref;
    logic [31:0] tempc;
    logic [15:0] adc_data;
    logic        busy;
    logic        done;
    logic        sat;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_adc = 16'h0000;
    logic        aborted_done;

    typedef struct {
        logic [15:0] adc;
        logic        sat;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    temperature_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tc_base  (tc_base),
        .tc_ref   (tc_ref),
        .tempc    (tempc),
        .adc_data (adc_data),
        .busy     (busy),
        .done     (done),
        .sat      (sat),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written directly from the arithmetic definition using
    // 64-bit integers.
    function automatic exp_t model(input logic signed [31:0] b,
                                   input logic [7:0] r,
                                   input logic signed [31:0] t);
        exp_t   e;
        longint d;
        longint m;
        longint num;
        longint scale;
        longint q;
        d     = longint'(t) - longint'(b);
        m     = (d < 0) ? -d : d;
        num   = m * 32;
        scale = longint'(r) * longint'(r);
        e.sat = 1'b0;
        e.err = 1'b0;
        e.lat = 2;
        if (scale == 0) begin
            e.err = 1'b1;
            e.adc = 16'h0000;
        end else if (num >= scale * 32768) begin
            e.sat = 1'b1;
            e.adc = {(d < 0), 15'h7FFF};
        end else begin
            q     = num / scale;
            e.adc = {((d < 0) && (q != 0)), q[14:0]};
            e.lat = 17;
        end
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        assert (act === exp_v) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp_v);
        end
    endtask

    // Called at the first falling edge after the accept edge. It waits, with a
    // bound, for done and then compares the result and the latency.
    task automatic wait_result(input string tag);
        exp_t e;
        int   n;
        n = 0;
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        check_output({tag, "_hold"}, 32'(adc_data), 32'(last_adc));
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check_output({tag, "_latency"}, 32'(n + 1), 32'(e.lat));
        check_output({tag, "_adc"}, 32'(adc_data), 32'(e.adc));
        check_output({tag, "_sat"}, 32'(sat), 32'(e.sat));
        check_output({tag, "_err"}, 32'(err), 32'(e.err));
        last_adc = e.adc;
        @(posedge clk);
        @(negedge clk);
        check_output({tag, "_idle"}, 32'({busy, done}), 32'd0);
    endtask

    // Issues one request, scrambles the inputs after acceptance, and optionally
    // keeps start high through the conversion.
    task automatic apply_stimulus(input string tag,
                                  input logic signed [31:0] b,
                                  input logic [7:0] r,
                                  input logic signed [31:0] t,
                                  input logic hold);
        @(negedge clk);
        tc_base = b;
        tc_ref  = r;
        tempc   = t;
        start   = 1'b1;
        sb.push_back(model(b, r, t));
        @(posedge clk);
        @(negedge clk);
        start   = hold;
        tc_base = $urandom;
        tc_ref  = 8'($urandom);
        tempc   = $urandom;
        wait_result(tag);
        start = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        tc_base = 32'd0;
        tc_ref  = 8'd0;
        tempc   = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs", {12'd0, adc_data, busy, done, sat, err}, 32'd0);
        rst = 1'b0;

        apply_stimulus("pos_basic",  32'sd25, 8'd2,   32'sd30,   1'b0);
        apply_stimulus("neg_basic",  32'sd25, 8'd2,   32'sd20,   1'b0);
        apply_stimulus("zero_diff",  32'sd25, 8'd2,   32'sd25,   1'b0);
        apply_stimulus("truncate",   32'sd0,  8'd3,   32'sd7,    1'b0);
        apply_stimulus("sat_pos",    32'sd0,  8'd1,   32'sd2000, 1'b0);
        apply_stimulus("sat_neg",    32'sd0,  8'd1,  -32'sd2000, 1'b1);
        apply_stimulus("err_ref0",   32'sd5,  8'd0,   32'sd100,  1'b0);
        apply_stimulus("below_fs",   32'sd0,  8'd1,   32'sd1023, 1'b0);
        apply_stimulus("at_fs",      32'sd0,  8'd1,   32'sd1024, 1'b0);
        apply_stimulus("neg_q_zero", 32'sd0,  8'd255, -32'sd1,   1'b0);
        apply_stimulus("big_ref",    32'sd0,  8'd255, 32'sd1000000, 1'b1);
        apply_stimulus("extreme",    32'sh7FFFFFFF, 8'd255, 32'sh80000000, 1'b0);

        // Reset in the middle of a division, with start held high afterwards.
        @(negedge clk);
        tc_base = 32'sd25;
        tc_ref  = 8'd2;
        tempc   = 32'sd30;
        start   = 1'b1;
        @(posedge clk);
        aborted_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) aborted_done = 1'b1;
            if (k == 7) rst = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        check_output("abort_no_done", 32'(aborted_done), 32'd0);
        check_output("abort_outputs", {12'd0, adc_data, busy, done, sat, err}, 32'd0);
        last_adc = 16'h0000;
        rst = 1'b0;
        sb.push_back(model(32'sd25, 8'd2, 32'sd30));
        @(posedge clk);
        @(negedge clk);
        wait_result("restart");
        start = 1'b0;

        check_output("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
